// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, MSB first,
// using a ripple subtractor (B inverted, carry-in 1) for the trial subtraction.
module seq_restoring_divider #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH);

   // LOAD is the cycle between acceptance and the first iteration; it also
   // resolves the zero-divisor case so both paths share the same front edge.
   typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg;
   logic [WIDTH:0]    r_reg;
   logic [WIDTH-1:0]  q_reg;
   logic [WIDTH-1:0]  dvs_reg;
   logic [WIDTH-1:0]  quotient_reg;
   logic [WIDTH-1:0]  remainder_reg;
   logic              dz_reg;

   logic              ready;
   logic              accept;
   logic              last_iter;
   logic [WIDTH:0]    shifted;
   logic [WIDTH:0]    sub_b;
   logic [WIDTH:0]    trial_sum;
   logic [WIDTH+1:0]  carry;
   logic              no_borrow;
   logic [WIDTH:0]    r_next;
   logic [WIDTH-1:0]  q_next;

   assign ready     = (state_reg == IDLE) || (state_reg == DONE);
   assign accept    = ready && start;
   assign last_iter = (cnt_reg == CNT_W'(WIDTH - 1));

   // Trial subtraction R - {0,divisor} as an add of the inverted operand.
   assign shifted  = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
   assign sub_b    = ~{1'b0, dvs_reg};
   assign carry[0] = 1'b1;

   genvar gi;
   generate
      for (gi = 0; gi <= WIDTH; gi++) begin : g_ripple
         assign trial_sum[gi] = shifted[gi] ^ sub_b[gi] ^ carry[gi];
         assign carry[gi+1]   = (shifted[gi] & sub_b[gi]) |
                                (carry[gi] & (shifted[gi] ^ sub_b[gi]));
      end
   endgenerate

   assign no_borrow = carry[WIDTH+1];
   assign r_next    = no_borrow ? trial_sum : shifted;
   assign q_next    = {q_reg[WIDTH-2:0], no_borrow};

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE, DONE: state_next = accept ? LOAD : IDLE;
         LOAD:       state_next = (dvs_reg == '0) ? DONE : CALC;
         CALC:       state_next = last_iter ? DONE : CALC;
         default:    state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         r_reg         <= '0;
         q_reg         <= '0;
         dvs_reg       <= '0;
         quotient_reg  <= '0;
         remainder_reg <= '0;
         dz_reg        <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            dvs_reg <= divisor;
            q_reg   <= dividend;
            r_reg   <= '0;
            cnt_reg <= '0;
            if (divisor != '0)
               dz_reg <= 1'b0;
         end else if (state_reg == CALC) begin
            r_reg   <= r_next;
            q_reg   <= q_next;
            cnt_reg <= cnt_reg + 1'b1;
            if (last_iter) begin
               quotient_reg  <= q_next;
               remainder_reg <= r_next[WIDTH-1:0];
            end
         end else if ((state_reg == LOAD) && (dvs_reg == '0)) begin
            // q_reg still holds the untouched dividend here.
            quotient_reg  <= '1;
            remainder_reg <= q_reg;
            dz_reg        <= 1'b1;
         end
      end
   end

   assign busy        = (state_reg == CALC);
   assign done        = (state_reg == DONE);
   assign quotient    = quotient_reg;
   assign remainder   = remainder_reg;
   assign div_by_zero = dz_reg;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed cases, a full operand
// sweep with back-to-back starts, and random operations against an arithmetic model.
module tb_seq_restoring_divider;

   localparam int W    = 4;
   localparam int MAXV = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int checks = 0;
   int errors = 0;

   seq_restoring_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void model(input int a, input int b,
                                 output int q, output int r, output int dz);
      if (b == 0) begin
         q = MAXV; r = a; dz = 1;
      end else begin
         q = a / b; r = a % b; dz = 0;
      end
   endfunction

   // Called at the first falling edge after the accepting edge; lat counts
   // rising edges from acceptance to the edge that raised done.
   task automatic wait_done(input int lat0, input bit scramble,
                            output int lat, output int busy_n);
      lat = lat0;
      busy_n = 0;
      while (!done && lat < 64) begin
         busy_n += int'(busy);
         if (scramble) begin
            dividend = W'($urandom);
            divisor  = W'($urandom);
         end
         @(negedge clk);
         lat++;
      end
      if (!done) check("done_timeout", 0, 1);
   endtask

   task automatic do_op(input int a, input int b, input bit scramble, input string tag);
      int eq, er, edz, lat, bn;
      model(a, b, eq, er, edz);
      dividend = W'(a);
      divisor  = W'(b);
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(0, scramble, lat, bn);
      check({tag, "_quotient"}, int'(quotient), eq);
      check({tag, "_remainder"}, int'(remainder), er);
      check({tag, "_dz"}, int'(div_by_zero), edz);
      check({tag, "_latency"}, lat, (b == 0) ? 1 : W + 1);
      check({tag, "_busy_cycles"}, bn, (b == 0) ? 0 : W);
      $display("op %s %0d/%0d -> q=%0d r=%0d dz=%0d lat=%0d busy=%0d",
               tag, a, b, quotient, remainder, div_by_zero, lat, bn);
   endtask

   initial begin
      int lat, bn, pulses;

      repeat (3) @(negedge clk);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_quotient", int'(quotient), 0);
      check("reset_remainder", int'(remainder), 0);
      check("reset_dz", int'(div_by_zero), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic operation and hold of results
      do_op(13, 3, 1'b0, "basic");
      @(negedge clk);
      check("basic_done_falls", int'(done), 0);
      repeat (2) @(negedge clk);
      check("basic_hold_q", int'(quotient), 4);
      check("basic_hold_r", int'(remainder), 1);

      // Every operand pair, each new start issued in the previous DONE cycle
      for (int a = 0; a <= MAXV; a++)
         for (int b = 0; b <= MAXV; b++)
            do_op(a, b, 1'b0, "sweep");
      @(negedge clk);

      // Zero divisor then clear of the flag
      do_op(9, 0, 1'b0, "divzero");
      do_op(8, 2, 1'b0, "after_dz");
      @(negedge clk);

      // Start during CALC is ignored
      dividend = 4'd14; divisor = 4'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("ign_busy", int'(busy), 1);
      dividend = 4'd7; divisor = 4'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(2, 1'b0, lat, bn);
      check("ign_latency", lat, W + 1);
      check("ign_quotient", int'(quotient), 3);
      check("ign_remainder", int'(remainder), 2);
      pulses = 0;
      repeat (W + 4) begin
         @(negedge clk);
         pulses += int'(done);
      end
      check("ign_extra_done", pulses, 0);
      $display("op ignored_start 14/4 -> q=%0d r=%0d", quotient, remainder);

      // Reset in the middle of an operation
      dividend = 4'd11; divisor = 4'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_quotient", int'(quotient), 0);
      check("abort_remainder", int'(remainder), 0);
      check("abort_dz", int'(div_by_zero), 0);
      pulses = 0;
      repeat (W + 4) begin
         @(negedge clk);
         pulses += int'(done);
      end
      check("abort_no_done", pulses, 0);
      $display("op aborted 11/2 -> outputs cleared, done pulses=%0d", pulses);
      do_op(11, 2, 1'b0, "after_abort");

      // Operand inputs changing during CALC
      @(negedge clk);
      do_op(12, 5, 1'b1, "scramble");

      // Random operations with random idle gaps
      for (int i = 0; i < 60; i++) begin
         int a, b;
         a = int'($urandom_range(MAXV, 0));
         b = (i % 10 == 0) ? 0 : int'($urandom_range(MAXV, 0));
         repeat ($urandom_range(2, 0)) @(negedge clk);
         do_op(a, b, 1'b0, "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
